// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Accept -> EXEC (ALU drives) -> RESP (result held until taken).
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } req_t;

  state_t state, state_nxt;
  logic   last_grant;   // winner of the most recently completed op
  logic   cur_id;       // owner of the op currently in flight
  logic   grant0, grant1;
  req_t   win_req;

  // Tie goes to whoever did not win last; a lone requester always wins.
  assign grant0  = req0_valid && (!req1_valid || last_grant);
  assign grant1  = req1_valid && (!req0_valid || !last_grant);
  assign win_req = grant1 ? req_t'{req1_a, req1_b, req1_op}
                          : req_t'{req0_a, req0_b, req0_op};

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Next state and ready; ready is gated by rst_n so every output reads 0 while in reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n && grant0;
        req1_ready = rst_n && grant1;
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch on accept, result capture in EXEC, fairness pointer on response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cur_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (grant0 || grant1) begin
          alu_a  <= win_req.a;
          alu_b  <= win_req.b;
          alu_op <= win_req.op;
          cur_id <= grant1;
        end
        EXEC: begin
          rsp_data <= alu_result;
          rsp_id   <= cur_id;
        end
        RESP: if (rsp_ready) last_grant <= rsp_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level model:
// one op in flight at a time, result due two cycles after accept, held until taken.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Reference ALU: AND, OR, ADD, SUB, SLT (signed), XOR for anything else.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  // Shared unit the DUT drives.
  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: pending op per requester, held until the model says it was accepted.
  logic        pend[2];
  logic [31:0] pa[2], pb[2];
  logic [3:0]  pop[2];
  int          p_new[2];
  int          p_rdy;
  logic        force_tie;

  // Transaction model.
  logic        m_last;       // requester that won the last completed op
  logic        m_inflight;
  int          m_age;        // cycles since accept of the in-flight op
  logic        m_id;
  logic [31:0] m_a, m_b;     // last accepted operands (also what alu_* must show)
  logic [3:0]  m_op;

  task automatic model_reset();
    m_last = 1'b1; m_inflight = 1'b0; m_age = 0; m_id = 1'b0;
    m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++)
      if (!pend[r] && (force_tie || $urandom_range(99) < p_new[r])) begin
        pend[r] = 1'b1; pa[r] = $urandom; pb[r] = $urandom; pop[r] = 4'($urandom_range(7));
      end
    force_tie  = 1'b0;
    req0_valid = pend[0];
    req0_a     = pend[0] ? pa[0] : $urandom;
    req0_b     = pend[0] ? pb[0] : $urandom;
    req0_op    = pend[0] ? pop[0] : 4'($urandom);
    req1_valid = pend[1];
    req1_a     = pend[1] ? pa[1] : $urandom;
    req1_b     = pend[1] ? pb[1] : $urandom;
    req1_op    = pend[1] ? pop[1] : 4'($urandom);
    rsp_ready  = ($urandom_range(99) < p_rdy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_r0"},   {31'b0, req0_ready}, 32'd0);
    chk({tag, "_r1"},   {31'b0, req1_ready}, 32'd0);
    chk({tag, "_rv"},   {31'b0, rsp_valid},  32'd0);
    chk({tag, "_rd"},   rsp_data,            32'd0);
    chk({tag, "_rid"},  {31'b0, rsp_id},     32'd0);
    chk({tag, "_aa"},   alu_a,               32'd0);
    chk({tag, "_ab"},   alu_b,               32'd0);
    chk({tag, "_aop"},  {28'b0, alu_op},     32'd0);
    chk({tag, "_busy"}, {31'b0, busy},       32'd0);
  endtask

  // Compare DUT outputs against the model for the current cycle.
  task automatic check_cycle();
    logic w0, w1, e_rv;
    w0   = pend[0] && (!pend[1] || m_last == 1'b1);
    w1   = pend[1] && (!pend[0] || m_last == 1'b0);
    e_rv = m_inflight && (m_age >= 2);
    chk("ready0", {31'b0, req0_ready}, {31'b0, !m_inflight && w0});
    chk("ready1", {31'b0, req1_ready}, {31'b0, !m_inflight && w1});
    chk("busy",   {31'b0, busy},       {31'b0, m_inflight});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
    chk("alu_a",  alu_a, m_a);
    chk("alu_b",  alu_b, m_b);
    chk("alu_op", {28'b0, alu_op}, {28'b0, m_op});
    if (e_rv) begin
      chk("rsp_data", rsp_data, ref_alu(m_a, m_b, m_op));
      chk("rsp_id",   {31'b0, rsp_id}, {31'b0, m_id});
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_step();
    logic w0, w1;
    w0 = pend[0] && (!pend[1] || m_last == 1'b1);
    w1 = pend[1] && (!pend[0] || m_last == 1'b0);
    if (!m_inflight) begin
      if (w0 || w1) begin
        m_id = w1; m_inflight = 1'b1; m_age = 1;
        m_a = pa[m_id]; m_b = pb[m_id]; m_op = pop[m_id];
        pend[m_id] = 1'b0;
      end
    end else if (m_age < 2) begin
      m_age++;
    end else if (rsp_ready) begin
      m_last = m_id; m_inflight = 1'b0;
    end
  endtask

  initial begin
    logic rst_done = 1'b0;
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = '1; req0_b = '1; req0_op = '1;
    req1_a = '1; req1_b = '1; req1_op = '1;
    pend[0] = 1'b0; pend[1] = 1'b0; force_tie = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First op: req0 OR, expecting 0x0F0F_F0F0 with id 0.
    pend[0] = 1'b1; pa[0] = 32'h0000_F0F0; pb[0] = 32'h0F0F_0000; pop[0] = 4'd1;

    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 40)       begin p_new[0] = 100; p_new[1] = 100; p_rdy = 100; end // ties
      else if (cyc < 80)  begin p_new[0] = 0;   p_new[1] = 100; p_rdy = 100; end // lone req1
      else if (cyc < 160) begin p_new[0] = 70;  p_new[1] = 70;  p_rdy = 15;  end // backpressure
      else                begin p_new[0] = 40;  p_new[1] = 40;  p_rdy = 60;  end
      drive();
      if (cyc >= 300 && !rst_done && m_inflight && m_age == 1) begin
        // Asynchronous reset while in EXEC: outputs drop at once, op is lost.
        rst_done = 1'b1;
        rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        force_tie = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      #1 check_cycle();
      model_step();
      @(negedge clk);
    end

    if (!rst_done) chk("midrst_reached", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
